// File: rtl/div_unit.sv
// div_unit: iterative restoring radix-2 divider for DIV/DIVU.
// Ports: clk, rst (sync, active-high), signed_div, opdata1 (dividend),
//   opdata2 (divisor), start, annul -> result {rem, quot}, ready.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BYZERO,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             qneg;
  logic             rneg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] rem_fin;
  logic [WIDTH-1:0] quot_fin;

  assign op1_abs = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign op2_abs = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // quot holds the not-yet-consumed dividend bits in its upper part;
  // its MSB is the next bit shifted into the partial remainder.
  assign rem_sh = {rem, quot[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs};

  assign rem_fin  = rneg ? -rem : rem;
  assign quot_fin = qneg ? -quot : quot;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          state_nx = (opdata2 == '0) ? BYZERO : BUSY;
        end
      end
      BYZERO: state_nx = annul ? IDLE : DONE;
      BUSY: begin
        if (annul) begin
          state_nx = IDLE;
        end else if (cnt == LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (annul || !start) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b0;
      result <= '0;
      cnt    <= '0;
      dvs    <= '0;
      quot   <= '0;
      rem    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          ready  <= 1'b0;
          result <= '0;
          if (state_nx == BUSY) begin
            dvs  <= op2_abs;
            quot <= op1_abs;
            rem  <= '0;
            cnt  <= '0;
            qneg <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            rneg <= signed_div & opdata1[WIDTH-1];
          end
        end
        BYZERO: begin
          result <= '0;
          ready  <= (state_nx == DONE);
        end
        BUSY: begin
          if (state_nx == IDLE) begin
            ready  <= 1'b0;
            result <= '0;
          end else if (state_nx == DONE) begin
            ready  <= 1'b1;
            result <= {rem_fin, quot_fin};
          end else begin
            // Trial subtract: a clear top bit means rem_sh >= divisor.
            if (!diff[WIDTH+1]) begin
              rem <= diff[WIDTH-1:0];
            end else begin
              rem <= rem_sh[WIDTH-1:0];
            end
            quot <= {quot[WIDTH-2:0], ~diff[WIDTH+1]};
            cnt  <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (state_nx == IDLE) begin
            ready  <= 1'b0;
            result <= '0;
          end
        end
        default: begin
          ready  <= 1'b0;
          result <= '0;
        end
      endcase
    end
  end

endmodule
